// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the CPU instruction-fetch stage:
//   WORD_W       - machine word width (instructions and word addresses)
//   NOP_INSTR_C  - encoding injected into IF/ID as a bubble
//   RESET_PC_C   - default PC after reset
//   fetch_state_e- RUN / PEND redirect-tracking states
//   ifid_op_e    - command to the IF/ID register (hold / bubble / load)
//   pc_inc()     - 16-bit modulo PC increment
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INSTR_C = 16'h0800;
  localparam word_t RESET_PC_C  = 16'h0000;

  // RUN: no redirect outstanding. PEND: a redirect arrived while the SRAM was
  // busy, so the target is parked until the delay-slot fetch completes.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_e;

  // Word addresses wrap modulo 2^16.
  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// The IF/ID pipeline register.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous reset, active-low
//   op_i     - IFID_HOLD keeps contents, IFID_BUBBLE injects NOP (pc kept),
//              IFID_LOAD captures instr_i / pc_i as a valid instruction
//   instr_i  - fetched instruction word
//   pc_i     - PC+1 of the fetched instruction
//   instr_o  - registered instruction
//   pc_o     - registered PC+1
//   valid_o  - registered instruction is real (not a bubble)
// -----------------------------------------------------------------------------
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_C
) (
  input  logic     clk,
  input  logic     rst,
  input  ifid_op_e op_i,
  input  word_t    instr_i,
  input  word_t    pc_i,
  output word_t    instr_o,
  output word_t    pc_o,
  output logic     valid_o
);

  word_t instr_q;
  word_t pc_q;
  logic  valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (op_i)
        IFID_BUBBLE: begin
          // The PC field is left alone so ID still sees the last real PC+1.
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        IFID_LOAD: begin
          instr_q <= instr_i;
          pc_q    <= pc_i;
          valid_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 16-bit pipelined CPU. Owns the PC register,
// the next-PC select and the IF/ID register (if_id_reg).
//
// Ports:
//   clk              - clock, rising edge
//   rst              - synchronous reset, active-low
//   instr_rdata      - instruction word for pc_addr, same cycle
//   mem_busy         - SRAM used by MEM stage; this cycle's fetch fails
//   stall_id         - ID hazard stall; PC, IF/ID and state hold
//   jump_n           - 0 = instruction in ID is a branch/jump
//   br_taken         - ID resolved the transfer as taken (needs jump_n==0)
//   br_target        - redirect target from ID (used unmodified)
//   pc_addr          - current fetch address
//   if_id_instr      - IF/ID instruction
//   if_id_pc         - IF/ID PC+1
//   if_id_valid      - IF/ID holds a real instruction
//   redirect_pending - redirect parked, waiting for the delay-slot fetch
//
// Build option BRANCH_FLUSH_EN: when defined, there is no delay slot. A
// redirect flushes IF/ID with a bubble and loads the target immediately,
// even if the SRAM is busy; redirect_pending is then always 0.
// -----------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_C,
  parameter word_t NOP_INSTR = NOP_INSTR_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] instr_rdata,
  input  logic              mem_busy,
  input  logic              stall_id,
  input  logic              jump_n,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_target,
  output logic [WORD_W-1:0] pc_addr,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              redirect_pending
);

  word_t    pc_q;
  word_t    pc_d;
  word_t    pc_plus1;
  ifid_op_e ifid_op;
  logic     redirect;

  // br_taken only counts when the jump decoder flags a control transfer.
  assign redirect = ~jump_n & br_taken;
  assign pc_plus1 = pc_inc(pc_q);

`ifdef BRANCH_FLUSH_EN

  // Next-PC select without a delay slot: redirect wins over a busy SRAM
  // because the fetch in flight is discarded anyway.
  always_comb begin
    pc_d    = pc_q;
    ifid_op = IFID_HOLD;
    if (!stall_id) begin
      if (redirect) begin
        pc_d    = br_target;
        ifid_op = IFID_BUBBLE;
      end else if (mem_busy) begin
        ifid_op = IFID_BUBBLE;
      end else begin
        pc_d    = pc_plus1;
        ifid_op = IFID_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign redirect_pending = 1'b0;

`else

  fetch_state_e state_q;
  word_t        tgt_q;

  // Next-PC select with a delay slot: the instruction at pc_addr is always
  // fetched before the PC moves to a branch target.
  always_comb begin
    pc_d    = pc_q;
    ifid_op = IFID_HOLD;
    if (!stall_id) begin
      if (mem_busy) begin
        ifid_op = IFID_BUBBLE;
      end else begin
        ifid_op = IFID_LOAD;
        if (state_q == ST_PEND) begin
          pc_d = tgt_q;
        end else if (redirect) begin
          pc_d = br_target;
        end else begin
          pc_d = pc_plus1;
        end
      end
    end
  end

  // PC register plus the RUN/PEND tracker. A redirect that meets a busy SRAM
  // cannot move the PC yet (the delay slot has not been fetched), so its
  // target is parked in tgt_q. A second redirect while parked simply
  // replaces the target.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      tgt_q   <= '0;
    end else begin
      pc_q <= pc_d;
      if (!stall_id) begin
        case (state_q)
          ST_RUN: begin
            if (mem_busy && redirect) begin
              tgt_q   <= br_target;
              state_q <= ST_PEND;
            end
          end
          ST_PEND: begin
            if (mem_busy) begin
              if (redirect) begin
                tgt_q <= br_target;
              end
            end else begin
              state_q <= ST_RUN;
            end
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign redirect_pending = (state_q == ST_PEND);

`endif

  assign pc_addr = pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .op_i    (ifid_op),
    .instr_i (instr_rdata),
    .pc_i    (pc_plus1),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_rdata;
  logic        mem_busy;
  logic        stall_id;
  logic        jump_n;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] pc_addr;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        redirect_pending;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .instr_rdata      (instr_rdata),
    .mem_busy         (mem_busy),
    .stall_id         (stall_id),
    .jump_n           (jump_n),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .pc_addr          (pc_addr),
    .if_id_instr      (if_id_instr),
    .if_id_pc         (if_id_pc),
    .if_id_valid      (if_id_valid),
    .redirect_pending (redirect_pending)
  );

  // Instruction memory image: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  assign instr_rdata = mem_word(pc_addr);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ifpc;
    logic        valid;
    logic        pend;
  } snap_t;

  snap_t sb_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model state
  logic [15:0] m_pc, m_instr, m_ifpc, m_tgt;
  logic        m_valid, m_pend;

  function automatic snap_t observe();
    return {pc_addr, if_id_instr, if_id_pc, if_id_valid, redirect_pending};
  endfunction

  // Drive one cycle of inputs, advance the model, push the expected post-edge
  // state, then step past the edge.
  task automatic cycle(input logic r, input logic busy, input logic stall,
                       input logic jn, input logic bt, input logic [15:0] tgt);
    logic  redir;
    snap_t e;
    rst       = r;
    mem_busy  = busy;
    stall_id  = stall;
    jump_n    = jn;
    br_taken  = bt;
    br_target = tgt;
    redir     = !jn && bt;
    if (!r) begin
      m_pc = 16'h0000; m_instr = NOP; m_ifpc = 16'h0000;
      m_valid = 1'b0; m_pend = 1'b0; m_tgt = 16'h0000;
    end else if (!stall) begin
`ifdef BRANCH_FLUSH_EN
      if (redir) begin
        m_instr = NOP; m_valid = 1'b0; m_pc = tgt;
      end else if (busy) begin
        m_instr = NOP; m_valid = 1'b0;
      end else begin
        m_instr = mem_word(m_pc); m_ifpc = m_pc + 16'd1; m_valid = 1'b1;
        m_pc = m_pc + 16'd1;
      end
`else
      if (busy) begin
        m_instr = NOP; m_valid = 1'b0;
        if (redir) begin
          m_tgt = tgt; m_pend = 1'b1;
        end
      end else begin
        m_instr = mem_word(m_pc); m_ifpc = m_pc + 16'd1; m_valid = 1'b1;
        if (m_pend) begin
          m_pc = m_tgt; m_pend = 1'b0;
        end else if (redir) begin
          m_pc = tgt;
        end else begin
          m_pc = m_pc + 16'd1;
        end
      end
`endif
    end
    e = {m_pc, m_instr, m_ifpc, m_valid, m_pend};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e, o;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_sb got=%h exp=%h", o, e); end
    end
    total++;
    if ({pc_addr, if_id_valid, if_id_instr, if_id_pc, redirect_pending} !==
        {16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got pc=%h v=%b i=%h ipc=%h p=%b exp pc=0000 v=0 i=0800 ipc=0000 p=0",
               pc_addr, if_id_valid, if_id_instr, if_id_pc, redirect_pending);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL free_run_sb got=%h exp=%h", o, e); end
      total++;
      if (pc_addr !== 16'(i + 1) || if_id_pc !== 16'(i + 1)) begin
        bad++;
        $display("FAIL free_run pc=%h ipc=%h exp=%h", pc_addr, if_id_pc, 16'(i + 1));
      end
    end
  endtask

  task automatic test_taken_branch();
    snap_t e, o;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL to_pc5_sb got=%h exp=%h", o, e); end
    end
    total++;
    if (pc_addr !== 16'h0005) begin bad++; $display("FAIL at_pc5 got=%h exp=0005", pc_addr); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL branch_sb got=%h exp=%h", o, e); end
    total++;
`ifdef BRANCH_FLUSH_EN
    if ({pc_addr, if_id_instr, if_id_valid} !== {16'h0040, NOP, 1'b0}) begin
      bad++;
      $display("FAIL branch_flush got pc=%h i=%h v=%b exp pc=0040 i=0800 v=0",
               pc_addr, if_id_instr, if_id_valid);
    end
`else
    if ({pc_addr, if_id_instr, if_id_pc, if_id_valid} !==
        {16'h0040, mem_word(16'h0005), 16'h0006, 1'b1}) begin
      bad++;
      $display("FAIL branch_delay_slot got pc=%h i=%h ipc=%h v=%b exp pc=0040 i=%h ipc=0006 v=1",
               pc_addr, if_id_instr, if_id_pc, if_id_valid, mem_word(16'h0005));
    end
`endif
  endtask

  task automatic test_busy_redirect();
    snap_t e, o;
    // Move to 0010 with a free-cycle redirect.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL to_0010_sb got=%h exp=%h", o, e); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0080);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL busy_redir_sb got=%h exp=%h", o, e); end
    total++;
`ifdef BRANCH_FLUSH_EN
    if ({pc_addr, if_id_instr, if_id_valid, redirect_pending} !== {16'h0080, NOP, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL busy_flush got pc=%h i=%h v=%b p=%b exp pc=0080 i=0800 v=0 p=0",
               pc_addr, if_id_instr, if_id_valid, redirect_pending);
    end
`else
    if ({pc_addr, if_id_instr, if_id_valid, redirect_pending} !== {16'h0010, NOP, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL busy_park got pc=%h i=%h v=%b p=%b exp pc=0010 i=0800 v=0 p=1",
               pc_addr, if_id_instr, if_id_valid, redirect_pending);
    end
`endif
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL pend_release_sb got=%h exp=%h", o, e); end
`ifndef BRANCH_FLUSH_EN
    total++;
    if ({pc_addr, if_id_instr, if_id_pc, if_id_valid, redirect_pending} !==
        {16'h0080, mem_word(16'h0010), 16'h0011, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL pend_release got pc=%h i=%h ipc=%h v=%b p=%b exp pc=0080 i=%h ipc=0011 v=1 p=0",
               pc_addr, if_id_instr, if_id_pc, if_id_valid, redirect_pending, mem_word(16'h0010));
    end
`endif
    // Newer target overwrites; busy with no redirect keeps the parked target.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL ovr1_sb got=%h exp=%h", o, e); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL ovr2_sb got=%h exp=%h", o, e); end
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL busy_hold_sb got=%h exp=%h", o, e); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL ovr_release_sb got=%h exp=%h", o, e); end
`ifndef BRANCH_FLUSH_EN
    total++;
    if (pc_addr !== 16'h0200) begin bad++; $display("FAIL overwrite got=%h exp=0200", pc_addr); end
`endif
  endtask

  task automatic test_stall();
    snap_t       e, o;
    logic [15:0] held_pc;
    held_pc = m_pc;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'(i == 1), 1'b1, 1'b0, 1'b1, 16'h00C0);
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_sb got=%h exp=%h", o, e); end
      total++;
      if (pc_addr !== held_pc || redirect_pending !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold pc=%h p=%b exp pc=%h p=0", pc_addr, redirect_pending, held_pc);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00C0);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL stall_release_sb got=%h exp=%h", o, e); end
    total++;
    if (pc_addr !== 16'h00C0) begin bad++; $display("FAIL stall_release got=%h exp=00C0", pc_addr); end
    // Stall while a redirect is parked must not disturb it.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00D0);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL stall_park_sb got=%h exp=%h", o, e); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00E0);
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_pend_sb got=%h exp=%h", o, e); end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL stall_pend_rel_sb got=%h exp=%h", o, e); end
    total++;
`ifdef BRANCH_FLUSH_EN
    if (pc_addr !== 16'h00D1) begin bad++; $display("FAIL stall_pend_rel got=%h exp=00D1", pc_addr); end
`else
    if (pc_addr !== 16'h00D0) begin bad++; $display("FAIL stall_pend_rel got=%h exp=00D0", pc_addr); end
`endif
  endtask

  task automatic test_wrap_qualify();
    snap_t e, o;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL to_ffff_sb got=%h exp=%h", o, e); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL wrap_sb got=%h exp=%h", o, e); end
    total++;
    if ({pc_addr, if_id_pc, if_id_instr} !== {16'h0000, 16'h0000, mem_word(16'hFFFF)}) begin
      bad++;
      $display("FAIL wrap_unqualified got pc=%h ipc=%h i=%h exp pc=0000 ipc=0000 i=%h",
               pc_addr, if_id_pc, if_id_instr, mem_word(16'hFFFF));
    end
  endtask

  task automatic test_reset_mid_redirect();
    snap_t e, o;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0500);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL mid_park_sb got=%h exp=%h", o, e); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0600);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL mid_reset_sb got=%h exp=%h", o, e); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    e = sb_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL mid_after_sb got=%h exp=%h", o, e); end
    total++;
    if ({pc_addr, redirect_pending} !== {16'h0001, 1'b0}) begin
      bad++;
      $display("FAIL reset_discards_target got pc=%h p=%b exp pc=0001 p=0", pc_addr, redirect_pending);
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 49) != 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 9) >= 3),
            1'($urandom_range(0, 1)),
            16'($urandom));
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL random_sb cyc=%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  initial begin
    rst = 1'b0; mem_busy = 1'b0; stall_id = 1'b0;
    jump_n = 1'b1; br_taken = 1'b0; br_target = 16'h0000;
    #2;
    test_reset();
    test_taken_branch();
    test_busy_redirect();
    test_stall();
    test_wrap_qualify();
    test_reset_mid_redirect();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
